// File: rtl/exp5_pkg.sv
// Shared state encodings and defaults for the Experiencia 5 memory-game control unit.
package exp5_pkg;

  // Encodings are shown directly on the 7-segment debug display.
  typedef enum logic [3:0] {
    S_INICIAL     = 4'h0,
    S_PREPARACAO  = 4'h1,
    S_ESPERA      = 4'h2,
    S_REGISTRA    = 4'h4,
    S_COMPARACAO  = 4'h5,
    S_PROXIMO     = 4'h6,
    S_FIM_ACERTOU = 4'hA,
    S_FIM_ERROU   = 4'hE,
    S_FIM_TIMEOUT = 4'hF
  } estado_t;

  localparam int TIMEOUT_CYCLES_DEF = 5000;

endpackage

// File: rtl/exp5_contador_timeout.sv
// Saturating cycle counter for the espera timeout; clear wins over enable.
module exp5_contador_timeout #(
  parameter int MAX = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic fim
);

  localparam int W = (MAX > 1) ? $clog2(MAX) : 1;

  logic [W-1:0] cnt;

  assign fim = (cnt == W'(MAX - 1));

  // Holds at MAX-1 so a long wait can never wrap back to zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)             cnt <= '0;
    else if (clear)         cnt <= '0;
    else if (enable && !fim) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/exp5_unidade_controle.sv
// Moore control unit sequencing one round of the memory game over exp4_fluxo_dados.
// Optional espera timeout enabled by defining EXP5_TIMEOUT_EN.
module exp5_unidade_controle
  import exp5_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       chavesIgualMemoria,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  estado_t estado, prox_estado;
  logic    tmo_fim;

`ifdef EXP5_TIMEOUT_EN
  exp5_contador_timeout #(
    .MAX (TIMEOUT_CYCLES)
  ) u_tmo (
    .clock  (clock),
    .reset  (reset),
    .clear  (estado != S_ESPERA),
    .enable (estado == S_ESPERA),
    .fim    (tmo_fim)
  );
`else
  assign tmo_fim = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= S_INICIAL;
    else        estado <= prox_estado;
  end

  always_comb begin
    prox_estado = S_INICIAL;
    zeraC       = 1'b0;
    zeraR       = 1'b0;
    contaC      = 1'b0;
    registraR   = 1'b0;
    pronto      = 1'b0;
    acertou     = 1'b0;
    errou       = 1'b0;
    timeout     = 1'b0;
    unique case (estado)
      S_INICIAL:    prox_estado = iniciar ? S_PREPARACAO : S_INICIAL;
      S_PREPARACAO: begin
        zeraC       = 1'b1;
        zeraR       = 1'b1;
        prox_estado = S_ESPERA;
      end
      // A player entry in the terminal timeout cycle still counts.
      S_ESPERA: begin
        if (jogada)       prox_estado = S_REGISTRA;
        else if (tmo_fim) prox_estado = S_FIM_TIMEOUT;
        else              prox_estado = S_ESPERA;
      end
      S_REGISTRA: begin
        registraR   = 1'b1;
        prox_estado = S_COMPARACAO;
      end
      // Mismatch outranks the last-address flag.
      S_COMPARACAO: begin
        if (!chavesIgualMemoria) prox_estado = S_FIM_ERROU;
        else if (fimC)           prox_estado = S_FIM_ACERTOU;
        else                     prox_estado = S_PROXIMO;
      end
      S_PROXIMO: begin
        contaC      = 1'b1;
        prox_estado = S_ESPERA;
      end
      S_FIM_ACERTOU: begin
        pronto      = 1'b1;
        acertou     = 1'b1;
        prox_estado = iniciar ? S_PREPARACAO : S_FIM_ACERTOU;
      end
      S_FIM_ERROU: begin
        pronto      = 1'b1;
        errou       = 1'b1;
        prox_estado = iniciar ? S_PREPARACAO : S_FIM_ERROU;
      end
      S_FIM_TIMEOUT: begin
        pronto      = 1'b1;
`ifdef EXP5_TIMEOUT_EN
        timeout     = 1'b1;
`endif
        prox_estado = iniciar ? S_PREPARACAO : S_FIM_TIMEOUT;
      end
      default:      prox_estado = S_INICIAL;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_exp5_unidade_controle.sv
// Directed bench for exp5_unidade_controle: a round-level reference model checked every cycle
// plus hand-computed literal expectations for each scenario.
module tb_exp5_unidade_controle;

  localparam int TCYC = 8;
`ifdef EXP5_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0, jogada = 1'b0, chv = 1'b1, fimC = 1'b0;
  logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int checks = 0, failures = 0, conta_n = 0;
  int m_code = 0, m_tcnt = 0;

  exp5_unidade_controle #(.TIMEOUT_CYCLES(TCYC)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .chavesIgualMemoria(chv), .fimC(fimC), .zeraC(zeraC), .contaC(contaC),
    .zeraR(zeraR), .registraR(registraR), .pronto(pronto), .acertou(acertou),
    .errou(errou), .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Round-level rules: which phase follows from the current phase and inputs.
  function automatic int model_next(int c, bit ini, bit jog, bit eq, bit fim, int tc);
    if (c == 0 || c >= 10) return ini ? 1 : c;
    if (c == 1) return 2;
    if (c == 2) return jog ? 4 : ((TMO && tc == TCYC - 1) ? 15 : 2);
    if (c == 4) return 5;
    if (c == 5) return !eq ? 14 : (fim ? 10 : 6);
    return 2;
  endfunction

  // Expected {db_estado, zeraC, zeraR, registraR, contaC, pronto, acertou, errou, timeout}.
  function automatic logic [11:0] model_out(int c);
    return {4'(c), c == 1, c == 1, c == 4, c == 6, c >= 10, c == 10, c == 14, c == 15};
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_code = 0;
      m_tcnt = 0;
    end else begin
      int nc;
      nc     = model_next(m_code, iniciar, jogada, chv, fimC, m_tcnt);
      m_tcnt = (m_code == 2) ? ((m_tcnt < TCYC - 1) ? m_tcnt + 1 : m_tcnt) : 0;
      m_code = nc;
    end
  end

  always @(negedge clock) begin
    logic [11:0] got, exp;
    got = {db_estado, zeraC, zeraR, registraR, contaC, pronto, acertou, errou, timeout};
    exp = model_out(m_code);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, got, exp);
    end
    if (contaC === 1'b1) conta_n++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One entry from espera; returns in espera, or in the final state when the round ends.
  task automatic entry(bit eq, bit fim);
    jogada = 1'b1; chv = eq; fimC = fim;
    tick();
    jogada = 1'b0;
    tick();
    tick();
    if (eq && !fim) tick();
    chv = 1'b1; fimC = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and start
    repeat (2) tick();
    check("reset_estado", db_estado, 0);
    check("reset_outs", {zeraC, zeraR, registraR, contaC, pronto, acertou, errou, timeout}, 0);
    reset = 1'b1;
    tick();
    check("idle_estado", db_estado, 0);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check("prep_estado", db_estado, 1);
    check("prep_zera", {zeraC, zeraR}, 2'b11);
    tick();
    check("espera_estado", db_estado, 2);

    // Full correct round
    conta_n = 0;
    for (int i = 0; i < 16; i++) entry(1'b1, i == 15);
    check("round_ok_estado", db_estado, 4'hA);
    check("round_ok_flags", {pronto, acertou, errou}, 3'b110);
    check("round_ok_conta", conta_n, 15);

    // Restart from a finished round
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check("restart_prep", db_estado, 1);
    check("restart_flags", {pronto, acertou}, 2'b00);
    tick();
    check("restart_espera", db_estado, 2);

    // Error on third entry
    conta_n = 0;
    entry(1'b1, 1'b0);
    entry(1'b1, 1'b0);
    entry(1'b0, 1'b0);
    check("err_estado", db_estado, 4'hE);
    check("err_flags", {pronto, errou, acertou}, 3'b110);
    check("err_conta", conta_n, 2);

    // Held jogada and iniciar mid-round; the per-cycle model covers the details
    iniciar = 1'b1;
    tick();
    tick();
    jogada = 1'b1;
    repeat (10) tick();
    jogada = 1'b0; iniciar = 1'b0;
    repeat (3) tick();
    check("held_settle", db_estado, 2);

    // Asynchronous reset in comparacao
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
    tick();
    check("pre_async", db_estado, 5);
    #2 reset = 1'b0;
    #1;
    check("async_estado", db_estado, 0);
    check("async_outs", {zeraC, zeraR, registraR, contaC, pronto, acertou, errou, timeout}, 0);
    tick();
    reset = 1'b1;
    tick();
    check("post_async", db_estado, 0);

`ifdef EXP5_TIMEOUT_EN
    // Timeout after TCYC idle cycles in espera
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    repeat (TCYC - 1) tick();
    check("tmo_last_wait", db_estado, 2);
    tick();
    check("tmo_estado", db_estado, 4'hF);
    check("tmo_flags", {pronto, timeout}, 2'b11);
    // Entry in the terminal cycle wins over timeout
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    repeat (TCYC - 1) tick();
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
    check("tmo_jogada_estado", db_estado, 4);
    check("tmo_jogada_flag", timeout, 0);
    repeat (3) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
